// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, HALT encoding and fetch FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t HALT_INSTR = 32'hFFFF_FFFF;
    localparam word_t NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Sequential next PC; wraps modulo 2^32.
    function automatic word_t next_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Signal bundle between the PC/imem side, the hazard unit and the IF/ID latch.
interface if_stage_if #(
    parameter int unsigned CNT_W = 16
) ();
    import cpu_types_pkg::*;

    word_t            imemaddr;
    word_t            imemload;
    logic             ihit;
    logic             stall;
    logic             flush;
    logic             imemREN;
    logic             pcEN;
    word_t            instr_o;
    word_t            npc_o;
    logic             valid_o;
    logic             halt_o;
    logic [CNT_W-1:0] wait_cnt_o;

    modport stage (
        input  imemaddr, imemload, ihit, stall, flush,
        output imemREN, pcEN, instr_o, npc_o, valid_o, halt_o, wait_cnt_o
    );

    modport bench (
        output imemaddr, imemload, ihit, stall, flush,
        input  imemREN, pcEN, instr_o, npc_o, valid_o, halt_o, wait_cnt_o
    );

endinterface

// File: rtl/if_stage_latch.sv
// Instruction fetch stage: IF/ID pipeline latch, FETCH/HALTED control FSM and
// a saturating fetch-wait performance counter.
module if_stage_latch
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic        CLK,
    input logic        nRST,
    if_stage_if.stage  bus
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    word_t            instr_q;
    word_t            npc_q;
    logic             valid_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             fetching;
    logic             capture;

    assign fetching = (state_q == FETCH);
    assign capture  = fetching && bus.ihit && !bus.stall && !bus.flush;

    // Next-state logic; flush from any state recovers a wrong-path HALT.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FETCH;
        end else if (capture && (bus.imemload == HALT_INSTR)) begin
            state_d = HALTED;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // IF/ID latch: flush squashes, a clean hit captures, otherwise hold.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.flush) begin
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else if (capture) begin
            instr_q <= bus.imemload;
            npc_q   <= next_pc(bus.imemaddr);
            valid_q <= 1'b1;
        end
    end

    // Saturating count of cycles where a read is outstanding without a hit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt_q <= '0;
        end else if (fetching && !bus.ihit && (wait_cnt_q != '1)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign bus.imemREN    = fetching;
    assign bus.pcEN       = (fetching && bus.ihit && !bus.stall) || bus.flush;
    assign bus.instr_o    = instr_q;
    assign bus.npc_o      = npc_q;
    assign bus.valid_o    = valid_q;
    assign bus.halt_o     = (state_q == HALTED);
    assign bus.wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_if_stage_latch.sv
// Directed self-checking bench for if_stage_latch with CNT_W=4.
module tb_if_stage_latch;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_fail;

    if_stage_if #(.CNT_W(4)) bus ();

    if_stage_latch #(.CNT_W(4)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus.stage)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] load,
                         input logic hit, input logic stl, input logic fl);
        bus.imemaddr = addr;
        bus.imemload = load;
        bus.ihit     = hit;
        bus.stall    = stl;
        bus.flush    = fl;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_instr"}, bus.instr_o, 32'h0);
        check({tag, "_npc"},   bus.npc_o,   32'h0);
        check({tag, "_valid"}, {31'h0, bus.valid_o}, 32'h0);
        check({tag, "_halt"},  {31'h0, bus.halt_o},  32'h0);
        check({tag, "_wcnt"},  {28'h0, bus.wait_cnt_o}, 32'h0);
        check({tag, "_ren"},   {31'h0, bus.imemREN}, 32'h1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #10;
        check_all_zero("reset");

        // First fetch straight after reset release.
        nrst = 1'b1;
        drive(32'h0, 32'h8C01_0004, 1'b1, 1'b0, 1'b0);
        check("cap1_pcen", {31'h0, bus.pcEN}, 32'h1);
        tick();
        check("cap1_instr", bus.instr_o, 32'h8C01_0004);
        check("cap1_npc",   bus.npc_o,   32'h0000_0004);
        check("cap1_valid", {31'h0, bus.valid_o}, 32'h1);
        check("cap1_wcnt",  {28'h0, bus.wait_cnt_o}, 32'h0);

        // Three miss cycles, then a hit.
        drive(32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("miss_pcen", {31'h0, bus.pcEN}, 32'h0);
            tick();
        end
        check("miss_wcnt",  {28'h0, bus.wait_cnt_o}, 32'h3);
        check("miss_hold",  bus.instr_o, 32'h8C01_0004);
        drive(32'h4, 32'h2002_0005, 1'b1, 1'b0, 1'b0);
        check("hit_pcen", {31'h0, bus.pcEN}, 32'h1);
        tick();
        check("cap2_instr", bus.instr_o, 32'h2002_0005);
        check("cap2_npc",   bus.npc_o,   32'h0000_0008);
        check("cap2_wcnt",  {28'h0, bus.wait_cnt_o}, 32'h3);

        // Stall holds the latch even with a hit present.
        drive(32'h8, 32'h1111_1111, 1'b1, 1'b1, 1'b0);
        check("stall_pcen", {31'h0, bus.pcEN}, 32'h0);
        tick();
        tick();
        check("stall_instr", bus.instr_o, 32'h2002_0005);
        check("stall_npc",   bus.npc_o,   32'h0000_0008);
        check("stall_valid", {31'h0, bus.valid_o}, 32'h1);

        // Flush beats stall and hit.
        drive(32'h8, 32'h1111_1111, 1'b1, 1'b1, 1'b1);
        check("flush_pcen", {31'h0, bus.pcEN}, 32'h1);
        tick();
        check("flush_instr", bus.instr_o, 32'h0);
        check("flush_npc",   bus.npc_o,   32'h0);
        check("flush_valid", {31'h0, bus.valid_o}, 32'h0);
        check("flush_wcnt",  {28'h0, bus.wait_cnt_o}, 32'h3);

        // HALT capture.
        drive(32'hC, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        tick();
        check("halt1_halt",  {31'h0, bus.halt_o},  32'h1);
        check("halt1_ren",   {31'h0, bus.imemREN}, 32'h0);
        check("halt1_instr", bus.instr_o, 32'hFFFF_FFFF);
        check("halt1_npc",   bus.npc_o,   32'h0000_0010);
        drive(32'h10, 32'h2222_2222, 1'b1, 1'b0, 1'b0);
        check("halted_pcen", {31'h0, bus.pcEN}, 32'h0);
        drive(32'h10, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        tick();
        check("halted_wcnt",  {28'h0, bus.wait_cnt_o}, 32'h3);
        check("halted_hold",  bus.instr_o, 32'hFFFF_FFFF);

        // Flush out of HALTED.
        drive(32'h10, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
        check("hflush_pcen", {31'h0, bus.pcEN}, 32'h1);
        tick();
        check("hflush_halt",  {31'h0, bus.halt_o},  32'h0);
        check("hflush_ren",   {31'h0, bus.imemREN}, 32'h1);
        check("hflush_valid", {31'h0, bus.valid_o}, 32'h0);
        check("hflush_instr", bus.instr_o, 32'h0);

        // Second HALT at the top of the address space: npc wraps to 0.
        drive(32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        tick();
        check("halt2_halt",  {31'h0, bus.halt_o},  32'h1);
        check("halt2_npc",   bus.npc_o, 32'h0);
        check("halt2_valid", {31'h0, bus.valid_o}, 32'h1);
        drive(32'h0, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("halt2_stay_pcen", {31'h0, bus.pcEN}, 32'h0);
            tick();
            check("halt2_stay_halt", {31'h0, bus.halt_o}, 32'h1);
        end
        check("halt2_stay_instr", bus.instr_o, 32'hFFFF_FFFF);

        // Asynchronous reset while HALTED, mid-cycle.
        #2;
        nrst = 1'b0;
        #1;
        check_all_zero("rst_halted");
        nrst = 1'b1;

        // Capture, then a long stalled miss to saturate the 4-bit counter.
        drive(32'h100, 32'hABCD_0001, 1'b1, 1'b0, 1'b0);
        tick();
        check("cap3_instr", bus.instr_o, 32'hABCD_0001);
        check("cap3_npc",   bus.npc_o,   32'h0000_0104);
        drive(32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", {28'h0, bus.wait_cnt_o}, 32'hE);
        for (int i = 0; i < 7; i++) tick();
        check("sat_21",  {28'h0, bus.wait_cnt_o}, 32'hF);
        check("sat_hold", bus.instr_o, 32'hABCD_0001);

        // Reset pulse in the middle of the stalled miss.
        #3;
        nrst = 1'b0;
        #1;
        check_all_zero("rst_stall");
        check("rst_stall_pcen", {31'h0, bus.pcEN}, 32'h0);
        #2;
        nrst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
